shared_bus_arbiter: RTL and testbench

- Parametrised N-channel arbiter that legally merges several sources onto one shared output bus. It replaces multi-driver nets with a registered, single-driver mux.
- Round-robin arbitration, valid/ready handshake on every channel and on the output, a single registered output stage, and a saturating contention counter.
- Sits between multiple producer blocks and a single consumer or bus.

---
 rtl/shared_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_shared_bus_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/shared_bus_arbiter.sv
// Round-robin N-channel arbiter that merges valid/ready sources onto one registered output bus.
// Define SHARED_BUS_ARBITER_LOCK_EN to add in_lock, which reserves the bus for one channel's multi-beat burst.
module shared_bus_arbiter #(
   parameter  int N_CH  = 4,
   parameter  int W     = 8,
   parameter  int CNT_W = 16,
   localparam int SRC_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   in_valid,
   input  logic [N_CH*W-1:0] in_data,
`ifdef SHARED_BUS_ARBITER_LOCK_EN
   input  logic [N_CH-1:0]   in_lock,
`endif
   output logic [N_CH-1:0]   in_ready,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   output logic [SRC_W-1:0]  out_src,
   input  logic              out_ready,
   output logic [N_CH-1:0]   grant,
   output logic [CNT_W-1:0]  conflict_cnt
);

   // Handshake: a beat moves across a channel or the output only in a cycle where valid and ready are both 1.
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       data_q, data_d;
   logic [SRC_W-1:0]   src_q, src_d;
   logic [N_CH-1:0]    grant_q, grant_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SRC_W-1:0]   ptr_q, ptr_d;
   logic               lock_active_q, lock_active_d;
   logic [SRC_W-1:0]   lock_owner_q, lock_owner_d;

   logic [N_CH-1:0]    elig;
   logic [SRC_W-1:0]   win;
   logic               found;
   logic               load;
   logic               contended;

   always_comb begin
      elig = in_valid;
`ifdef SHARED_BUS_ARBITER_LOCK_EN
      if (lock_active_q) begin
         elig = in_valid & (N_CH'(1) << lock_owner_q);
      end
`endif
   end

   // First eligible channel at or above ptr, wrapping past N_CH-1 to 0.
   always_comb begin
      int idx;
      found = 1'b0;
      win   = ptr_q;
      for (int k = 0; k < N_CH; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N_CH) begin
            idx = idx - N_CH;
         end
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = SRC_W'(idx);
         end
      end
   end

   assign load      = found && ((state_q == EMPTY) || out_ready);
   assign contended = |(in_valid & (in_valid - N_CH'(1)));

   always_comb begin
      in_ready = '0;
      if (load && rst_n) begin
         in_ready[win] = 1'b1;
      end
   end

   always_comb begin
      state_d       = state_q;
      data_d        = data_q;
      src_d         = src_q;
      grant_d       = grant_q;
      cnt_d         = cnt_q;
      ptr_d         = ptr_q;
      lock_active_d = lock_active_q;
      lock_owner_d  = lock_owner_q;
      if (load) begin
         state_d = FULL;
         data_d  = in_data[int'(win)*W +: W];
         src_d   = win;
         grant_d = N_CH'(1) << win;
         ptr_d   = (int'(win) == N_CH-1) ? '0 : win + SRC_W'(1);
         if (contended && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
`ifdef SHARED_BUS_ARBITER_LOCK_EN
         // Under lock the winner is always the owner, so this both starts and ends bursts.
         lock_active_d = in_lock[win];
         lock_owner_d  = win;
`endif
      end else if ((state_q == FULL) && out_ready) begin
         state_d = EMPTY;
         grant_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= EMPTY;
         data_q        <= '0;
         src_q         <= '0;
         grant_q       <= '0;
         cnt_q         <= '0;
         ptr_q         <= '0;
         lock_active_q <= 1'b0;
         lock_owner_q  <= '0;
      end else begin
         state_q       <= state_d;
         data_q        <= data_d;
         src_q         <= src_d;
         grant_q       <= grant_d;
         cnt_q         <= cnt_d;
         ptr_q         <= ptr_d;
         lock_active_q <= lock_active_d;
         lock_owner_q  <= lock_owner_d;
      end
   end

   assign out_valid    = (state_q == FULL);
   assign out_data     = data_q;
   assign out_src      = src_q;
   assign grant        = grant_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter; a second instance with CNT_W=2 shares the inputs to show saturation.
module tb_shared_bus_arbiter;

   localparam int N_CH = 4;
   localparam int W    = 8;

   logic            clk;
   logic            rst_n;
   logic [N_CH-1:0] in_valid;
   logic [N_CH*W-1:0] in_data;
   logic [N_CH-1:0] in_lock;
   logic [N_CH-1:0] in_ready, in_ready2;
   logic            out_valid, out_valid2;
   logic [W-1:0]    out_data, out_data2;
   logic [1:0]      out_src, out_src2;
   logic            out_ready;
   logic [N_CH-1:0] grant, grant2;
   logic [15:0]     conflict_cnt;
   logic [1:0]      conflict_cnt2;

   int checks = 0;
   int errors = 0;

   shared_bus_arbiter #(.N_CH(N_CH), .W(W), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
`ifdef SHARED_BUS_ARBITER_LOCK_EN
      .in_lock(in_lock),
`endif
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_src(out_src), .out_ready(out_ready), .grant(grant),
      .conflict_cnt(conflict_cnt)
   );

   shared_bus_arbiter #(.N_CH(N_CH), .W(W), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
`ifdef SHARED_BUS_ARBITER_LOCK_EN
      .in_lock(in_lock),
`endif
      .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
      .out_src(out_src2), .out_ready(out_ready), .grant(grant2),
      .conflict_cnt(conflict_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [W-1:0] d);
      in_data[ch*W +: W] = d;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 4'b1111;
      in_lock   = '0;
      out_ready = 1'b1;
      for (int i = 0; i < N_CH; i++) set_ch(i, 8'hA0 + 8'(i));
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_cnt", 32'(conflict_cnt), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("rr_first_ready", 32'(in_ready), 32'h1);

      // Round robin with all channels valid; dut_sat shows 1,2,3,3,3,3.
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rr_valid", 32'(out_valid), 32'h1);
         chk("rr_src", 32'(out_src), 32'(i % 4));
         chk("rr_data", 32'(out_data), 32'(8'hA0 + 8'(i % 4)));
         chk("rr_grant", 32'(grant), 32'(4'b0001 << (i % 4)));
         chk("rr_cnt", 32'(conflict_cnt), 32'(i + 1));
         chk("sat_cnt", 32'(conflict_cnt2), 32'((i + 1 > 3) ? 3 : i + 1));
      end

      // Drain: out_valid and grant drop, data/src keep last beat (ch1, A1).
      in_valid = '0;
      tick();
      chk("drain_valid", 32'(out_valid), 32'h0);
      chk("drain_grant", 32'(grant), 32'h0);
      chk("drain_data", 32'(out_data), 32'hA1);
      chk("drain_src", 32'(out_src), 32'h1);

      // Backpressure with ch2 holding 8'h5C; ptr is 2 here.
      set_ch(2, 8'h5C);
      in_valid  = 4'b0100;
      out_ready = 1'b0;
      #1;
      chk("bp_load_ready", 32'(in_ready), 32'h4);
      tick();
      set_ch(0, 8'h11);
      in_valid = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_data", 32'(out_data), 32'h5C);
         chk("bp_src", 32'(out_src), 32'h2);
         chk("bp_grant", 32'(grant), 32'h4);
         chk("bp_in_ready", 32'(in_ready), 32'h0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'h1);
      tick();
      chk("bp_next_src", 32'(out_src), 32'h0);
      chk("bp_next_data", 32'(out_data), 32'h11);
      chk("bp_cnt_flat", 32'(conflict_cnt), 32'h6);

      // Wrap: ch3 wins from ptr 1, then ptr wraps to 0.
      set_ch(3, 8'h33);
      in_valid = 4'b1000;
      tick();
      chk("wrap_src3", 32'(out_src), 32'h3);
      in_valid = 4'b0011;
      #1;
      chk("wrap_ptr0", 32'(in_ready), 32'h1);
      set_ch(1, 8'h44);
      in_valid = 4'b0010;
      #1;
      chk("single_ready", 32'(in_ready), 32'h2);
      tick();
      chk("single_src", 32'(out_src), 32'h1);
      chk("single_data", 32'(out_data), 32'h44);
      chk("single_cnt", 32'(conflict_cnt), 32'h6);

      // Mid-beat asynchronous reset while the held beat is stalled.
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      for (int i = 0; i < N_CH; i++) set_ch(i, 8'hA0 + 8'(i));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_grant", 32'(grant), 32'h0);
      chk("mid_rst_cnt", 32'(conflict_cnt), 32'h0);
      chk("mid_rst_src", 32'(out_src), 32'h0);
      chk("mid_rst_ready", 32'(in_ready), 32'h0);
      #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("post_rst_ready", 32'(in_ready), 32'h1);
      tick();
      chk("post_rst_src", 32'(out_src), 32'h0);
      chk("post_rst_data", 32'(out_data), 32'hA0);
      chk("post_rst_cnt", 32'(conflict_cnt), 32'h1);

`ifdef SHARED_BUS_ARBITER_LOCK_EN
      // ptr is 1: ch1 bursts three beats (lock 1,1,0) against ch0 and ch2.
      in_valid = 4'b0111;
      in_lock  = 4'b0010;
      tick();
      chk("lock_src_a", 32'(out_src), 32'h1);
      tick();
      chk("lock_src_b", 32'(out_src), 32'h1);
      in_lock = 4'b0000;
      tick();
      chk("lock_src_c", 32'(out_src), 32'h1);
      in_valid = 4'b0101;
      tick();
      chk("lock_resume", 32'(out_src), 32'h2);
      chk("lock_cnt", 32'(conflict_cnt), 32'h5);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
